decode_stage: RTL and testbench

Registered, parametrised RV32I instruction-decode pipeline stage. It accepts a fetched instruction and PC over a valid/ready handshake, decodes the full RV32I opcode map (plus RV32M when enabled), and generates the sign-extended immediate. Decoded control fields are held in an output pipeline register toward execute, with stall, flush and illegal-instruction flagging.

---
 rtl/decode_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I (+ optional RV32M) decode stage with a
// valid/ready handshake toward fetch and a single held bundle toward execute.
module decode_stage #(
  parameter bit          ENABLE_M = 1'b0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      pc,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [31:0]      imm,
  output logic             reg_write_enable,
  output logic             mem_write_enable,
  output logic             is_branch,
  output logic             is_jump,
  output logic             alu_input_config,
  output logic             illegal,
  output logic             is_ecall,
  output logic             is_ebreak,
  output logic [1:0]       result_src,
  output logic [2:0]       mem_size,
  output logic [2:0]       branch_cond,
  output logic [2:0]       imm_sel,
  output logic [5:0]       alu_op,
  output logic [CNT_W-1:0] decoded_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [2:0] SEL_I = 3'd0;
  localparam logic [2:0] SEL_U = 3'd1;
  localparam logic [2:0] SEL_J = 3'd2;
  localparam logic [2:0] SEL_B = 3'd3;
  localparam logic [2:0] SEL_S = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  localparam logic [5:0] ALU_ADD_IMM = 6'b000001;
  localparam logic [5:0] ALU_SUB     = 6'b010000;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        accept;

  logic [31:0] imm_c;
  logic        reg_write_c, mem_write_c, is_branch_c, is_jump_c;
  logic        alu_cfg_c, illegal_c, ecall_c, ebreak_c;
  logic [1:0]  result_src_c;
  logic [2:0]  mem_size_c, branch_cond_c, imm_sel_c;
  logic [5:0]  alu_op_c;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  // Reset forces ready so fetch is never blocked by an unknown out_valid.
  assign in_ready = rst || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    imm_c         = '0;
    reg_write_c   = 1'b0;
    mem_write_c   = 1'b0;
    is_branch_c   = 1'b0;
    is_jump_c     = 1'b0;
    alu_cfg_c     = 1'b1;
    illegal_c     = 1'b0;
    ecall_c       = 1'b0;
    ebreak_c      = 1'b0;
    result_src_c  = RES_ALU;
    mem_size_c    = 3'd0;
    branch_cond_c = 3'd0;
    imm_sel_c     = SEL_I;
    alu_op_c      = ALU_ADD_IMM;

    case (opcode)
      OP_REG: begin
        alu_cfg_c   = 1'b0;
        reg_write_c = 1'b1;
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          alu_op_c = {1'b0, in_instr[30], funct3, 1'b0};
        end else if (ENABLE_M && funct7 == F7_MUL) begin
          alu_op_c = {1'b1, 1'b0, funct3, 1'b0};
        end else begin
          illegal_c = 1'b1;
        end
      end
      OP_IMM: begin
        reg_write_c = 1'b1;
        imm_c       = imm_i;
        alu_op_c    = {1'b0, (funct3 == 3'b101) ? in_instr[30] : 1'b0, funct3, 1'b1};
        if (funct3 == 3'b001) begin
          imm_c = imm_sh;
          if (funct7 != F7_BASE) illegal_c = 1'b1;
        end else if (funct3 == 3'b101) begin
          imm_c = imm_sh;
          if (funct7 != F7_BASE && funct7 != F7_ALT) illegal_c = 1'b1;
        end
      end
      OP_LOAD: begin
        reg_write_c  = 1'b1;
        result_src_c = RES_MEM;
        mem_size_c   = funct3;
        imm_c        = imm_i;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal_c = 1'b1;
      end
      OP_STORE: begin
        mem_write_c = 1'b1;
        mem_size_c  = funct3;
        imm_sel_c   = SEL_S;
        imm_c       = imm_s;
        if (funct3 > 3'b010) illegal_c = 1'b1;
      end
      OP_BRANCH: begin
        is_branch_c   = 1'b1;
        branch_cond_c = funct3;
        imm_sel_c     = SEL_B;
        imm_c         = imm_b;
        alu_cfg_c     = 1'b0;
        alu_op_c      = ALU_SUB;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal_c = 1'b1;
      end
      OP_JAL: begin
        is_jump_c    = 1'b1;
        reg_write_c  = 1'b1;
        result_src_c = RES_PC4;
        imm_sel_c    = SEL_J;
        imm_c        = imm_j;
      end
      OP_JALR: begin
        is_jump_c    = 1'b1;
        reg_write_c  = 1'b1;
        result_src_c = RES_PC4;
        imm_c        = imm_i;
      end
      OP_LUI, OP_AUIPC: begin
        reg_write_c = 1'b1;
        imm_sel_c   = SEL_U;
        imm_c       = imm_u;
      end
      OP_FENCE: begin
        imm_c = imm_i;
      end
      OP_SYSTEM: begin
        imm_c    = imm_i;
        ecall_c  = (in_instr == INSTR_ECALL);
        ebreak_c = (in_instr == INSTR_EBREAK);
        if (!ecall_c && !ebreak_c) illegal_c = 1'b1;
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase

    // An illegal bundle must have no architectural side effects.
    if (illegal_c) begin
      reg_write_c = 1'b0;
      mem_write_c = 1'b0;
      is_branch_c = 1'b0;
      is_jump_c   = 1'b0;
      ecall_c     = 1'b0;
      ebreak_c    = 1'b0;
    end
    if (in_instr[11:7] == 5'd0) reg_write_c = 1'b0;
  end

  // Output bundle register: flush beats capture, capture beats pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      pc               <= '0;
      rd               <= '0;
      rs1              <= '0;
      rs2              <= '0;
      imm              <= '0;
      reg_write_enable <= 1'b0;
      mem_write_enable <= 1'b0;
      is_branch        <= 1'b0;
      is_jump          <= 1'b0;
      alu_input_config <= 1'b0;
      illegal          <= 1'b0;
      is_ecall         <= 1'b0;
      is_ebreak        <= 1'b0;
      result_src       <= '0;
      mem_size         <= '0;
      branch_cond      <= '0;
      imm_sel          <= '0;
      alu_op           <= '0;
      decoded_count    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid        <= 1'b1;
      pc               <= in_pc;
      rd               <= in_instr[11:7];
      rs1              <= in_instr[19:15];
      rs2              <= in_instr[24:20];
      imm              <= imm_c;
      reg_write_enable <= reg_write_c;
      mem_write_enable <= mem_write_c;
      is_branch        <= is_branch_c;
      is_jump          <= is_jump_c;
      alu_input_config <= alu_cfg_c;
      illegal          <= illegal_c;
      is_ecall         <= ecall_c;
      is_ebreak        <= ebreak_c;
      result_src       <= result_src_c;
      mem_size         <= mem_size_c;
      branch_cond      <= branch_cond_c;
      imm_sel          <= imm_sel_c;
      alu_op           <= alu_op_c;
      decoded_count    <= decoded_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus random checks of decode_stage (both with and
// without RV32M) against a behavioural decode model.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        rw, mw, br, jp, cfg, ill, ec, eb;
    logic [1:0]  rs;
    logic [2:0]  ms, bc, isel;
    logic [5:0]  aop;
  } bnd_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [1:0]  rdy_w, vld_w;
  logic [31:0] cnt_w [2];
  bnd_t        obs [2];

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_valid, exp_zero;
  logic [31:0] exp_cnt;
  bnd_t exp_b [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, mw, br, jp, cfg, ill, ec, eb;
    logic [1:0]  rs;
    logic [2:0]  ms, bc, isel;
    logic [5:0]  aop;

    decode_stage #(.ENABLE_M(1'(g)), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[g]),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(vld_w[g]), .out_ready(out_ready),
      .pc(pc), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .reg_write_enable(rw), .mem_write_enable(mw), .is_branch(br), .is_jump(jp),
      .alu_input_config(cfg), .illegal(ill), .is_ecall(ec), .is_ebreak(eb),
      .result_src(rs), .mem_size(ms), .branch_cond(bc), .imm_sel(isel),
      .alu_op(aop), .decoded_count(cnt_w[g])
    );

    assign obs[g] = {pc, rd, rs1, rs2, imm, rw, mw, br, jp, cfg, ill, ec, eb,
                     rs, ms, bc, isel, aop};
  end

  // Behavioural decode from the instruction-set rules.
  function automatic bnd_t ref_decode(input logic [31:0] w, input logic [31:0] p, input bit m);
    bnd_t b;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] ii;
    logic signed [12:0] bo;
    logic signed [20:0] jo;
    f3 = w[14:12];
    f7 = w[31:25];
    ii = 32'($signed(w) >>> 20);
    bo = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    jo = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    b = '0;
    b.pc = p; b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
    b.cfg = 1'b1; b.aop = 6'd1;
    case (w[6:0])
      7'h33: begin
        b.cfg = 1'b0; b.rw = 1'b1;
        if (m && f7 == 7'd1) b.aop = 6'(32 + 2 * int'(f3));
        else begin
          b.aop = 6'(16 * int'(w[30]) + 2 * int'(f3));
          b.ill = !((f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end
      end
      7'h13: begin
        b.rw = 1'b1;
        b.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(w[24:20]) : ii;
        b.aop = 6'(16 * int'(f3 == 3'd5 && w[30]) + 2 * int'(f3) + 1);
        b.ill = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'h20);
      end
      7'h03: begin
        b.rw = 1'b1; b.rs = 2'd1; b.ms = f3; b.imm = ii;
        b.ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'h23: begin
        b.mw = 1'b1; b.ms = f3; b.isel = 3'd4; b.imm = {ii[31:5], w[11:7]};
        b.ill = (f3 > 3'd2);
      end
      7'h63: begin
        b.br = 1'b1; b.bc = f3; b.isel = 3'd3; b.imm = 32'(bo); b.cfg = 1'b0;
        b.aop = 6'b010000; b.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h6F: begin b.jp = 1'b1; b.rs = 2'd2; b.rw = 1'b1; b.isel = 3'd2; b.imm = 32'(jo); end
      7'h67: begin b.jp = 1'b1; b.rs = 2'd2; b.rw = 1'b1; b.imm = ii; end
      7'h37, 7'h17: begin b.rw = 1'b1; b.isel = 3'd1; b.imm = w & 32'hFFFF_F000; end
      7'h0F: b.imm = ii;
      7'h73: begin
        b.imm = ii; b.ec = (w == 32'h73); b.eb = (w == 32'h0010_0073);
        b.ill = !(b.ec || b.eb);
      end
      default: b.ill = 1'b1;
    endcase
    if (b.ill) begin b.rw = 0; b.mw = 0; b.br = 0; b.jp = 0; b.ec = 0; b.eb = 0; end
    if (b.rd == 5'd0) b.rw = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [11];
    logic [6:0]  f7s [3];
    int k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01};
    w = $urandom();
    k = int'($urandom_range(0, 12));
    if (k < 11) w[6:0] = ops[k];
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
    if (k == 10 && $urandom_range(0, 1) == 1) w = ($urandom_range(0, 1) == 1) ? 32'h73 : 32'h0010_0073;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic check_outputs();
    for (int g = 0; g < 2; g++) begin
      chk("out_valid", 128'(vld_w[g]), 128'(exp_valid));
      chk("decoded_count", 128'(cnt_w[g]), 128'(exp_cnt));
      if (exp_valid && !exp_b[g].ill) chk("bundle", 128'(obs[g]), 128'(exp_b[g]));
      else if (exp_valid) begin
        chk("illegal_flag", 128'(obs[g].ill), 128'(1'b1));
        chk("illegal_pc", 128'(obs[g].pc), 128'(exp_b[g].pc));
        chk("illegal_effects", 128'({obs[g].rw, obs[g].mw, obs[g].br, obs[g].jp, obs[g].ec, obs[g].eb}),
            128'(6'b0));
      end else if (exp_zero) chk("reset_bundle", 128'(obs[g]), 128'(0));
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input logic fl, input logic r);
    logic er;
    in_valid = v; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl; rst = r;
    #1;
    er = r || !exp_valid || ordy;
    for (int g = 0; g < 2; g++) chk("in_ready", 128'(rdy_w[g]), 128'(er));
    @(posedge clk);
    if (r) begin
      exp_valid = 1'b0; exp_zero = 1'b1; exp_cnt = '0;
    end else if (fl) begin
      exp_valid = 1'b0;
    end else if (v && er) begin
      exp_valid = 1'b1; exp_zero = 1'b0; exp_cnt = exp_cnt + 32'd1;
      exp_b[0] = ref_decode(ins, p, 1'b0);
      exp_b[1] = ref_decode(ins, p, 1'b1);
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    exp_valid = 1'b0; exp_zero = 1'b1; exp_cnt = '0;
    exp_b[0] = '0; exp_b[1] = '0;

    cycle(0, 32'h0, 32'h0, 0, 0, 1);
    cycle(0, 32'h0, 32'h0, 1, 0, 1);

    cycle(1, 32'h0050_0093, 32'h100, 1, 0, 0);
    chk("addi_rd", 128'(obs[0].rd), 128'(5'd1));
    chk("addi_imm", 128'(obs[0].imm), 128'(32'd5));
    chk("addi_aluop", 128'(obs[0].aop), 128'(6'b000001));
    chk("addi_rw", 128'(obs[0].rw), 128'(1'b1));

    cycle(1, 32'h4020_81B3, 32'h104, 1, 0, 0);
    chk("sub_aluop", 128'(obs[0].aop), 128'(6'b010000));
    chk("sub_cfg", 128'(obs[0].cfg), 128'(1'b0));

    cycle(1, 32'h0220_81B3, 32'h108, 1, 0, 0);
    chk("mul_noM_illegal", 128'(obs[0].ill), 128'(1'b1));
    chk("mul_noM_rw", 128'(obs[0].rw), 128'(1'b0));
    chk("mul_M_aluop", 128'(obs[1].aop), 128'(6'b100000));
    chk("mul_M_legal", 128'(obs[1].ill), 128'(1'b0));

    cycle(0, 32'h0, 32'h0, 1, 0, 1);
    cycle(1, 32'h0050_0093, 32'h200, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h0020_8463, 32'h204, 0, 0, 0);
      chk("held_imm", 128'(obs[0].imm), 128'(32'd5));
    end
    cycle(1, 32'h0020_8463, 32'h204, 1, 0, 0);
    chk("beq_imm", 128'(obs[0].imm), 128'(32'd8));
    chk("beq_cond", 128'(obs[0].bc), 128'(3'b000));
    cycle(1, 32'h0020_A223, 32'h208, 1, 0, 0);
    chk("sw_imm", 128'(obs[0].imm), 128'(32'd4));
    chk("sw_mw", 128'(obs[0].mw), 128'(1'b1));
    chk("count_3", 128'(cnt_w[0]), 128'(32'd3));
    cycle(0, 32'h0, 32'h0, 1, 0, 0);

    cycle(1, 32'h0050_0093, 32'h20C, 1, 1, 0);
    chk("flush_count", 128'(cnt_w[0]), 128'(32'd3));

    cycle(1, 32'h0010_0013, 32'h210, 1, 0, 0);
    chk("x0_rw", 128'(obs[0].rw), 128'(1'b0));
    cycle(1, 32'hFFDF_F0EF, 32'h214, 1, 0, 0);
    chk("jal_imm", 128'(obs[0].imm), 128'(32'hFFFF_FFFC));
    chk("jal_rs", 128'(obs[0].rs), 128'(2'd2));
    chk("jal_jump", 128'(obs[0].jp), 128'(1'b1));
    cycle(1, 32'h0000_0073, 32'h218, 1, 0, 0);
    chk("ecall", 128'(obs[0].ec), 128'(1'b1));
    cycle(1, 32'h0010_0073, 32'h21C, 1, 0, 0);
    chk("ebreak", 128'(obs[0].eb), 128'(1'b1));
    cycle(1, 32'h0000_0000, 32'h220, 1, 0, 0);
    chk("zero_illegal", 128'(obs[0].ill), 128'(1'b1));
    cycle(1, 32'h0050_0093, 32'h224, 0, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 0, 1);
    chk("rst_valid", 128'(vld_w[0]), 128'(1'b0));

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 149) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
